// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter and its grant mux.
package arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SEND    = 2'd2,
      RELEASE = 2'd3
   } state_e;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder; when several bits are set the lowest one wins.
module onehot_to_bin #(
   parameter int P_N = 3,
   parameter int P_W = 2
) (
   input  logic [P_N-1:0] onehot,
   output logic [P_W-1:0] bin,
   output logic           hit
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      bin = '0;
      hit = 1'b0;
      for (int i = P_N - 1; i >= 0; i--) begin
         if (onehot[i]) begin
            bin = P_W'(i);
            hit = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/arbiter_grant_mux.sv
// Steers the granted requester's word into one registered valid/ready channel.
// Optional sticky non-one-hot grant detector: define ARB_GRANT_MUX_ONEHOT_CHECK_EN.
module arbiter_grant_mux
   import arbiter_pkg::*;
#(
   parameter  int P_REQUESTER_NUM = 3,
   parameter  int P_DATA_W        = 32,
   localparam int LP_IDX_W        = idx_width(P_REQUESTER_NUM)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [P_REQUESTER_NUM-1:0]          req_valid,
   input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] req_data,
   output logic [P_REQUESTER_NUM-1:0]          req_ready,
   input  logic [P_REQUESTER_NUM-1:0]          grant_valid,
   output logic                                grant_ready,
   output logic                                m_valid,
   output logic [P_DATA_W-1:0]                 m_data,
   output logic [LP_IDX_W-1:0]                 m_id,
   input  logic                                m_ready
`ifdef ARB_GRANT_MUX_ONEHOT_CHECK_EN
   ,
   output logic                                grant_err
`endif
);

   state_e                state_q, state_d;
   logic [LP_IDX_W-1:0]   gidx_q, gidx_d;
   logic                  m_valid_q, m_valid_d;
   logic [P_DATA_W-1:0]   m_data_q, m_data_d;
   logic [LP_IDX_W-1:0]   m_id_q, m_id_d;
   logic                  grant_ready_q, grant_ready_d;

   logic [LP_IDX_W-1:0]   grant_idx_s;
   logic                  grant_hit_s;
   logic [P_DATA_W-1:0]   sel_data_s;
   logic                  sel_valid_s;

   onehot_to_bin #(
      .P_N (P_REQUESTER_NUM),
      .P_W (LP_IDX_W)
   ) u_onehot_to_bin (
      .onehot (grant_valid),
      .bin    (grant_idx_s),
      .hit    (grant_hit_s)
   );

   // Data and valid of the requester latched at grant time.
   always_comb begin
      sel_data_s  = '0;
      sel_valid_s = 1'b0;
      for (int i = 0; i < P_REQUESTER_NUM; i++) begin
         if (gidx_q == LP_IDX_W'(i)) begin
            sel_data_s  = req_data[i*P_DATA_W +: P_DATA_W];
            sel_valid_s = req_valid[i];
         end else begin
         end
      end
   end

   // Pop pulse is combinational so reset removes it without a clock edge.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < P_REQUESTER_NUM; i++) begin
         req_ready[i] = (state_q == CAPTURE) && sel_valid_s && (gidx_q == LP_IDX_W'(i));
      end
   end

   always_comb begin
      state_d       = state_q;
      gidx_d        = gidx_q;
      m_valid_d     = m_valid_q;
      m_data_d      = m_data_q;
      m_id_d        = m_id_q;
      grant_ready_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_hit_s) begin
               gidx_d  = grant_idx_s;
               state_d = CAPTURE;
            end else begin
               state_d = IDLE;
            end
         end
         CAPTURE: begin
            if (sel_valid_s) begin
               m_data_d  = sel_data_s;
               m_id_d    = gidx_q;
               m_valid_d = 1'b1;
               state_d   = SEND;
            end else begin
               // Withdrawn request: release the grant anyway so the arbiter cannot stall.
               grant_ready_d = 1'b1;
               state_d       = RELEASE;
            end
         end
         SEND: begin
            if (m_ready) begin
               m_valid_d     = 1'b0;
               grant_ready_d = 1'b1;
               state_d       = RELEASE;
            end else begin
               state_d = SEND;
            end
         end
         RELEASE: begin
            if (grant_valid == '0) begin
               state_d = IDLE;
            end else begin
               state_d = RELEASE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef ARB_GRANT_MUX_ONEHOT_CHECK_EN
   localparam logic [P_REQUESTER_NUM-1:0] LP_ONE = P_REQUESTER_NUM'(1);

   logic grant_err_q, grant_err_d;
   logic multi_s;

   // Clearing the lowest set bit leaves something only if more than one was set.
   always_comb begin
      multi_s     = |(grant_valid & (grant_valid - LP_ONE));
      grant_err_d = grant_err_q | ((state_q == IDLE) && multi_s);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_err_q <= 1'b0;
      end else begin
         grant_err_q <= grant_err_d;
      end
   end

   assign grant_err = grant_err_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         gidx_q        <= '0;
         m_valid_q     <= 1'b0;
         m_data_q      <= '0;
         m_id_q        <= '0;
         grant_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         gidx_q        <= gidx_d;
         m_valid_q     <= m_valid_d;
         m_data_q      <= m_data_d;
         m_id_q        <= m_id_d;
         grant_ready_q <= grant_ready_d;
      end
   end

   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_id        = m_id_q;
   assign grant_ready = grant_ready_q;

endmodule

// File: doc/arbiter_grant_mux.md
Name: arbiter_grant_mux

Overview:
- Downstream stage of the weighted round-robin arbiter.
- Consumes the arbiter's one-hot grant and steers the granted requester's data word into one registered output channel (valid/ready).
- Pops the granted requester with a one-cycle ready pulse, then returns grant_ready to the arbiter once the downstream sink accepts the word.
- One grant transfers exactly one beat.

Parameters:
- P_REQUESTER_NUM, 3, number of requesters; must match the arbiter.
- P_DATA_W, 32, data width per requester.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  P_REQUESTER_NUM  per-requester data valid; the same vector drives the arbiter's request input.
- req_data  in  P_REQUESTER_NUM*P_DATA_W  packed data; requester i occupies bits [i*P_DATA_W +: P_DATA_W].
- req_ready  out  P_REQUESTER_NUM  one-cycle pop pulse to the granted requester.
- grant_valid  in  P_REQUESTER_NUM  one-hot grant from the arbiter.
- grant_ready  out  1  one-cycle pulse to the arbiter; the arbiter clears grant_valid on the next edge.
- m_valid  out  1  output word valid.
- m_data  out  P_DATA_W  output word.
- m_id  out  clog2(P_REQUESTER_NUM), minimum 1  index of the source requester.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (asynchronous, active-high) applies immediately: state=IDLE; req_ready=0, grant_ready=0, m_valid=0, m_data=0, m_id=0; grant_err=0 when present.
- Reset mid-transfer drops the captured word. The requester is not popped again. The arbiter is reset separately by the system.
- The FSM is registered. All outputs are registered except req_ready, which is decoded from state and the latched index.
- IDLE:
  - If grant_valid != 0, latch gidx = onehot_to_bin(grant_valid) and go to CAPTURE.
  - If grant_valid == 0, stay in IDLE.
- CAPTURE:
  - If req_valid[gidx]=1: req_ready[gidx]=1 this cycle; m_data <= req_data[gidx]; m_id <= gidx; m_valid <= 1; go to SEND.
  - If req_valid[gidx]=0 (requester withdrew): no pop; grant_ready pulses next cycle; go to RELEASE. This prevents arbiter deadlock.
- SEND:
  - Hold m_valid, m_data and m_id stable.
  - On m_valid & m_ready: m_valid <= 0; grant_ready <= 1 for exactly one cycle; go to RELEASE.
- RELEASE:
  - grant_ready is low again.
  - Wait until grant_valid == 0, then go to IDLE.
  - A nonzero grant_valid seen in RELEASE is never treated as a new grant.
- Latency:
  - Grant to m_valid: 2 cycles (IDLE → CAPTURE → SEND).
  - m_ready to grant_ready: 1 cycle.
  - Minimum cycles per beat: 5, counting the arbiter's idle cycle.
- At most one req_ready bit is high in any cycle, and only in CAPTURE.
- grant_ready never stays high for more than one cycle.
- Non-one-hot grant: the lowest set bit wins; see the optional feature.
- m_ready held high permanently: SEND lasts exactly 1 cycle.
- gidx is held from the IDLE latch until the FSM returns to IDLE, even if grant_valid changes meanwhile.

Optional Feature:
- Macro: ARB_GRANT_MUX_ONEHOT_CHECK_EN.
- Defined:
  - Adds output grant_err (1 bit, sticky, cleared only by rst).
  - grant_err is set on any cycle in IDLE where grant_valid has more than one bit set.
  - Datapath behaviour is unchanged (lowest set bit wins).
- Undefined: no grant_err port and no checker logic.

Decomposition:
- Package arbiter_pkg:
  - State enum: IDLE=2'd0, CAPTURE=2'd1, SEND=2'd2, RELEASE=2'd3.
  - Constant function for the index width: clog2 with a minimum of 1.
- Sub-module onehot_to_bin: combinational, priority to the lowest set bit. It is reusable by the arbiter's own testbench.

Test Plan:
- Single beat: req_valid=3'b010, req_data[1]=32'hA5A5_0001, grant_valid=3'b010, m_ready=1 → one req_ready=3'b010 pulse; m_valid with m_data=32'hA5A5_0001 and m_id=1 two cycles after the grant; grant_ready pulses once; FSM returns to IDLE after grant_valid drops.
- Backpressure: m_ready=0 for 7 cycles with requester 0 granted → m_valid, m_data and m_id stable for all 7 cycles; no grant_ready; one grant_ready the cycle after m_ready rises.
- Withdrawn request: grant_valid=3'b100, req_valid[2]=0 in CAPTURE → no req_ready; m_valid stays 0; grant_ready pulses once; no deadlock.
- Integration with the arbiter (weights 5,3,2): all requesters continuously valid for one full round → the m_id sequence contains 5× id0, 3× id1, 2× id2; every req_ready count matches.
- Async reset in SEND: assert rst mid-cycle → m_valid, grant_ready and req_ready go to 0 immediately, without waiting for a clock edge; after release the next grant is handled normally.
- With ARB_GRANT_MUX_ONEHOT_CHECK_EN: grant_valid=3'b011 in IDLE → m_id=0, grant_err=1 and stays 1 until rst.
